serial_deser: RTL and testbench
===============================

Name: serial_deser

Overview:
Serial-to-parallel receiver: the reading end for a bit stream produced by clock-enabled flip-flop chains.
- Samples one bit per enabled clock into a shift register.
- Delimits words with a frame_start marker.
- Presents each completed word on a valid/ready output port.
- Sits downstream of registered serial sources in lab datapaths; its output feeds a parallel consumer.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit is data_out[WIDTH-1]; 0 = first received bit is data_out[0].

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
clock_enable  in  1  bit strobe; serial_in and frame_start are ignored when low.
serial_in  in  1  serial data bit.
frame_start  in  1  qualified by clock_enable; marks the current bit as bit 0 of a new word.
data_out  out  WIDTH  last completed word.
data_valid  out  1  data_out holds an unconsumed word.
data_ready  in  1  consumer accepts the word on a clock edge where data_valid && data_ready.
overflow  out  1  sticky; a completed word was dropped.
busy  out  1  high while a frame is partially received (state SHIFT).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (port reset); sampled only on clk rising edge.
- Reset values: data_out=0, data_valid=0, overflow=0, busy=0. Internal shift register=0, bit count=0, state=IDLE.
- Reset mid-frame aborts the partial word; no word is produced.
- An "enabled cycle" is any rising edge with clock_enable=1. All other edges leave the receive state untouched. The output handshake still operates on every edge.
- FSM states are IDLE and SHIFT.
- IDLE:
  - Enabled cycle with frame_start=1: store serial_in as bit 0, count=1, go to SHIFT.
  - Enabled cycle with frame_start=0: stay in IDLE; the bit is discarded.
- SHIFT:
  - Enabled cycle with frame_start=0: store serial_in at position count, count+1.
  - When the stored bit is bit WIDTH-1, the word completes on that same edge; return to IDLE, count=0.
  - Enabled cycle with frame_start=1: abort the partial word and restart. serial_in becomes bit 0, count=1, stay in SHIFT. This is not an overflow.
- Bit placement:
  - MSB_FIRST=1: bit k maps to data_out[WIDTH-1-k].
  - MSB_FIRST=0: bit k maps to data_out[k].
- Completion latency: data_out/data_valid update on the same edge that samples the last bit, and are visible immediately after that edge. A back-to-back frame_start on the next enabled cycle is accepted, giving zero dead cycles.
- Output handshake; at a completion edge:
  - data_valid=0: load data_out, set data_valid=1.
  - data_valid=1 && data_ready=1: old word is consumed and the new word is loaded; data_valid stays 1.
  - data_valid=1 && data_ready=0: new word dropped, data_out unchanged, overflow set to 1.
- Non-completion edge with data_valid && data_ready: data_valid=0; data_out holds its last value.
- data_out must not change while data_valid=1 && data_ready=0.
- overflow is cleared only by reset.
- Count width is clog2(WIDTH)+1.
- No combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, data_ready=1, clock_enable=1 every cycle; frame_start with first bit, send 0xA5 -> data_valid=1 for exactly one cycle after the 8th edge; data_out=0xA5; busy high for 7 cycles; overflow=0.
2. Same config; send 0x3C with clock_enable low for 2 cycles between each bit, toggling serial_in during the disabled cycles -> data_out=0x3C; completion only after the 8th enabled edge.
3. data_ready=0: send 0xA5 then 0x0F back-to-back -> data_out stays 0xA5, overflow=1. Raise data_ready for one cycle -> data_valid=0; overflow remains 1.
4. Send 3 bits (1,1,0), then frame_start with a new frame 0x81 -> data_out=0x81; exactly one valid pulse; overflow=0.
5. Assert reset for 1 cycle after 5 bits of 0xFF -> all outputs 0 after that edge. Next full frame 0x5A -> data_out=0x5A.
6. MSB_FIRST=0; send bit sequence 1,0,1,0,0,1,0,1 -> data_out=0xA5. Simultaneously complete a second word 0x01 on the edge where data_ready=1 -> data_out=0x01, data_valid stays 1.

Source files
------------

// File: rtl/serial_deser.sv
// serial_deser: serial-to-parallel receiver.
//
// Samples one bit per enabled clock (clock_enable=1) into a shift register.
// A word starts at the bit that has frame_start=1. It completes when bit
// WIDTH-1 has been received. Each completed word is presented on a
// valid/ready output port.
//
// Handshake: data_out carries a word whenever data_valid=1. The word is
// consumed on a rising edge where data_valid && data_ready. data_out never
// changes while data_valid=1 && data_ready=0. If a word completes while the
// previous word is still unconsumed, the new word is dropped and overflow is
// set. overflow is sticky and only reset clears it.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   clock_enable in   bit strobe; serial_in and frame_start are ignored when low
//   serial_in    in   serial data bit
//   frame_start  in   current bit is bit 0 of a new word (qualified by clock_enable)
//   data_out     out  last completed word (WIDTH bits)
//   data_valid   out  data_out holds an unconsumed word
//   data_ready   in   consumer accepts the word
//   overflow     out  sticky flag: a completed word was dropped
//   busy         out  receive FSM is in SHIFT (exposes the FSM state)
//
// All outputs are registered. There is no combinational path from any input
// to any output.
module serial_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clock_enable,
  input  logic             serial_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             complete;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overflow_q;
  logic             busy_q;

  // Register position of received bit k.
  function automatic int bit_pos(input int k);
    return (MSB_FIRST != 0) ? (WIDTH - 1 - k) : k;
  endfunction

  // Receive path. shreg_d holds the complete word on the completion edge,
  // so it is loaded straight into data_q and the output updates on that
  // same edge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shreg_d  = shreg_q;
    complete = 1'b0;
    if (clock_enable) begin
      if (frame_start) begin
        // A new frame starts, or an in-flight partial word restarts.
        // Stale bits are cleared.
        shreg_d = '0;
        for (int b = 0; b < WIDTH; b++) begin
          if (b == bit_pos(0)) shreg_d[b] = serial_in;
        end
        count_d = CW'(1);
        state_d = SHIFT;
      end else if (state_q == SHIFT) begin
        for (int b = 0; b < WIDTH; b++) begin
          if (b == bit_pos(int'(count_q))) shreg_d[b] = serial_in;
        end
        if (int'(count_q) == WIDTH - 1) begin
          complete = 1'b1;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      busy_q  <= (state_d == SHIFT);
      if (complete) begin
        // Load the new word if the slot is empty or being emptied this edge.
        if (!valid_q || data_ready) begin
          data_q  <= shreg_d;
          valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser. Two instances share the stimulus: one
// with MSB_FIRST=1 and one with MSB_FIRST=0. The expected words below are
// worked out by hand from the transmitted bit order.
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       reset;
  logic       clock_enable;
  logic       serial_in;
  logic       frame_start;
  logic       data_ready;

  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, ovf_m, ovf_l, busy_m, busy_l;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cnt;
  int valid_cnt;

  serial_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .clock_enable(clock_enable),
    .serial_in(serial_in), .frame_start(frame_start),
    .data_out(data_m), .data_valid(valid_m), .data_ready(data_ready),
    .overflow(ovf_m), .busy(busy_m)
  );

  serial_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .clock_enable(clock_enable),
    .serial_in(serial_in), .frame_start(frame_start),
    .data_out(data_l), .data_valid(valid_l), .data_ready(data_ready),
    .overflow(ovf_l), .busy(busy_l)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Checker.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver. Inputs change at the falling edge, and outputs are observed at
  // the falling edge that follows the rising edge which sampled them.
  task automatic sample();
    if (busy_m)  busy_cnt++;
    if (valid_m) valid_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic send_bit(input logic b, input logic fs);
    clock_enable = 1'b1;
    serial_in    = b;
    frame_start  = fs;
    @(negedge clk);
    clock_enable = 1'b0;
    frame_start  = 1'b0;
  endtask

  // Sends seq[7], seq[6], ... (nbits of them), with frame_start on the first
  // bit. Each gap cycle is disabled, and serial_in and frame_start toggle
  // during it.
  task automatic send_frame(input logic [7:0] seq, input int nbits, input int gap);
    for (int k = 0; k < nbits; k++) begin
      send_bit(seq[7-k], k == 0);
      sample();
      if (k < nbits - 1) begin
        for (int g = 0; g < gap; g++) begin
          clock_enable = 1'b0;
          serial_in    = ~serial_in;
          frame_start  = ~frame_start;
          tick();
        end
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic clr_counts();
    busy_cnt  = 0;
    valid_cnt = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_m"},  data_m,  0);
    chk({tag, "_data_l"},  data_l,  0);
    chk({tag, "_valid_m"}, valid_m, 0);
    chk({tag, "_valid_l"}, valid_l, 0);
    chk({tag, "_ovf_m"},   ovf_m,   0);
    chk({tag, "_ovf_l"},   ovf_l,   0);
    chk({tag, "_busy_m"},  busy_m,  0);
    chk({tag, "_busy_l"},  busy_l,  0);
  endtask

  initial begin
    reset        = 1'b1;
    clock_enable = 1'b0;
    serial_in    = 1'b0;
    frame_start  = 1'b0;
    data_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_zero("rst");

    // 1: 0xA5, enabled every cycle, consumer always ready.
    clr_counts();
    send_frame(8'hA5, 8, 0);
    chk("t1_data_m", data_m, 8'hA5);
    chk("t1_data_l", data_l, 8'hA5);
    chk("t1_valid", valid_m, 1);
    chk("t1_busy_cnt", busy_cnt, 7);
    chk("t1_ovf", ovf_m, 0);
    tick();
    chk("t1_valid_drop", valid_m, 0);
    chk("t1_valid_cnt", valid_cnt, 1);
    chk("t1_hold", data_m, 8'hA5);

    // 2: 0x3C with two disabled cycles between bits.
    clr_counts();
    send_frame(8'h3C, 8, 2);
    chk("t2_data_m", data_m, 8'h3C);
    chk("t2_data_l", data_l, 8'h3C);
    chk("t2_valid", valid_m, 1);
    chk("t2_valid_cnt", valid_cnt, 1);
    chk("t2_busy_cnt", busy_cnt, 21);
    tick();
    chk("t2_valid_drop", valid_m, 0);

    // 3: consumer stalled, two back-to-back words.
    data_ready = 1'b0;
    send_frame(8'hA5, 8, 0);
    chk("t3_first_valid", valid_m, 1);
    chk("t3_first_data", data_m, 8'hA5);
    chk("t3_first_ovf", ovf_m, 0);
    send_frame(8'h0F, 8, 0);
    chk("t3_data_m", data_m, 8'hA5);
    chk("t3_data_l", data_l, 8'hA5);
    chk("t3_ovf_m", ovf_m, 1);
    chk("t3_ovf_l", ovf_l, 1);
    tick();
    chk("t3_stall_data", data_m, 8'hA5);
    chk("t3_stall_valid", valid_m, 1);
    data_ready = 1'b1;
    tick();
    chk("t3_consumed", valid_m, 0);
    chk("t3_ovf_sticky", ovf_m, 1);
    apply_reset();
    chk_zero("t3_rst");

    // 4: partial word 1,1,0 aborted by a new frame 0x81.
    clr_counts();
    send_frame(8'b1100_0000, 3, 0);
    chk("t4_busy_partial", busy_m, 1);
    chk("t4_no_valid", valid_m, 0);
    send_frame(8'h81, 8, 0);
    tick();
    chk("t4_data_m", data_m, 8'h81);
    chk("t4_data_l", data_l, 8'h81);
    chk("t4_valid_cnt", valid_cnt, 1);
    chk("t4_busy_cnt", busy_cnt, 10);
    chk("t4_ovf", ovf_m, 0);

    // 5: reset after 5 bits of 0xFF, then frame 0x5A.
    send_frame(8'hFF, 5, 0);
    chk("t5_busy_mid", busy_m, 1);
    apply_reset();
    chk_zero("t5_rst");
    send_frame(8'h5A, 8, 0);
    chk("t5_data_m", data_m, 8'h5A);
    chk("t5_data_l", data_l, 8'h5A);
    chk("t5_valid", valid_m, 1);
    tick();

    // 6: LSB-first 0xA5 held, then a second word completes on a ready edge.
    apply_reset();
    data_ready = 1'b0;
    send_frame(8'hA5, 8, 0);
    chk("t6_first_l", data_l, 8'hA5);
    chk("t6_first_valid_l", valid_l, 1);
    send_frame(8'h80, 7, 0);
    chk("t6_hold_l", data_l, 8'hA5);
    data_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("t6_data_l", data_l, 8'h01);
    chk("t6_data_m", data_m, 8'h80);
    chk("t6_valid_l", valid_l, 1);
    chk("t6_valid_m", valid_m, 1);
    chk("t6_ovf_l", ovf_l, 0);
    data_ready = 1'b0;
    tick();
    chk("t6_still_valid", valid_l, 1);
    chk("t6_still_data", data_l, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
